// File: rtl/wr_arb_pkg.sv
// Shared definitions for the write-burst arbiter: FSM state encoding and the
// round-robin successor helper used to seed the channel scan.
package wr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        SKIP  = 2'd3
    } arb_state_t;

    // Index that follows idx in a ring of num entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num);
        return (idx + 1) % num;
    endfunction

endpackage

// File: rtl/wr_burst_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of req at or after start,
// wrapping modulo N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    output logic           found,
    output logic [IDW-1:0] idx
);

    logic [IDW-1:0] j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IDW'((int'(start) + k) % N);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/wr_burst_arbiter.sv
// Round-robin arbiter sharing one AXI write-burst command engine among NUM
// channel status controllers. Optional watchdog: define ARB_WATCHDOG_EN.
module wr_burst_arbiter
    import wr_arb_pkg::*;
#(
    parameter int NUM       = 4,
    parameter int LSIZE     = 9,
    parameter int IDW       = 2,
    parameter int WD_CYCLES = 4096
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM-1:0]       burst_req,
    input  logic [NUM-1:0]       tail_req,
    input  logic [NUM*LSIZE-1:0] req_len,
    output logic [NUM-1:0]       resp,
    output logic [NUM-1:0]       done,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [LSIZE-1:0]     cmd_len,
    output logic [IDW-1:0]       cmd_id,
    output logic                 cmd_tail,
    input  logic                 eng_done,
    output logic                 busy,
    output logic                 wd_err
);

    arb_state_t       state, state_nxt;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   pick_start, pick_idx;
    logic             pick_found;
    logic [LSIZE-1:0] pick_len;
    logic             pick_tail;
    logic [NUM-1:0]   id_onehot;
    logic             skip_ph;
    logic             wd_timeout;
    logic             grant_fire, resp_fire, done_fire;

    assign pick_start = IDW'(rr_next(32'(last_grant), 32'(NUM)));

    rr_pick #(.N(NUM), .IDW(IDW)) u_pick (
        .req   (burst_req | tail_req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Tail takes priority when a channel raises both requests.
    always_comb begin
        pick_len  = '0;
        pick_tail = 1'b0;
        id_onehot = '0;
        for (int i = 0; i < NUM; i++) begin
            if (pick_idx == IDW'(i)) begin
                pick_len  = req_len[i*LSIZE +: LSIZE];
                pick_tail = tail_req[i];
            end
            id_onehot[i] = (cmd_id == IDW'(i));
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && pick_found) state_nxt = (pick_len == '0) ? SKIP : ISSUE;
            ISSUE:   if (cmd_ready) state_nxt = WAIT;
            WAIT:    if (eng_done || wd_timeout) state_nxt = IDLE;
            SKIP:    if (skip_ph) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // SKIP spends one cycle raising resp and one raising done, so a
    // requester that drops on resp is gone before IDLE scans again.
    always_comb begin
        cmd_valid  = (state == ISSUE);
        busy       = (state != IDLE);
        grant_fire = (state == IDLE) && enable && pick_found;
        resp_fire  = ((state == ISSUE) && cmd_ready) || ((state == SKIP) && !skip_ph);
        done_fire  = ((state == WAIT) && (eng_done || wd_timeout)) || ((state == SKIP) && skip_ph);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cmd_id     <= '0;
            cmd_len    <= '0;
            cmd_tail   <= 1'b0;
            last_grant <= IDW'(NUM - 1);
            resp       <= '0;
            done       <= '0;
            skip_ph    <= 1'b0;
        end else begin
            if (grant_fire) begin
                cmd_id   <= pick_idx;
                cmd_len  <= pick_len;
                cmd_tail <= pick_tail;
            end
            resp    <= resp_fire ? id_onehot : '0;
            done    <= done_fire ? id_onehot : '0;
            skip_ph <= (state == SKIP) && !skip_ph;
            if (done_fire) last_grant <= cmd_id;
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);

    logic [WDW-1:0] wd_cnt;
    logic           wd_err_q;

    // Counts cycles spent in WAIT; expiry releases the channel as if done.
    assign wd_timeout = (state == WAIT) && !eng_done && (wd_cnt == WDW'(WD_CYCLES - 1));
    assign wd_err     = wd_err_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wd_cnt   <= '0;
            wd_err_q <= 1'b0;
        end else begin
            if ((state == WAIT) && !wd_timeout) wd_cnt <= wd_cnt + 1'b1;
            else                                wd_cnt <= '0;
            if (wd_timeout) wd_err_q <= 1'b1;
        end
    end
`else
    assign wd_timeout = 1'b0;
    assign wd_err     = 1'b0;
`endif

endmodule
